// File: rtl/rgen_pkg.sv
// Shared types and constants for the register access arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rgen_pkg;

    // Access FSM state encoding
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ACCESS  = 2'd1;
    localparam state_t ST_RESPOND = 2'd2;

    // Response status carried on o_host_error
    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/rgen_round_robin_arbiter.sv
// Round-robin requester picker; search starts just after the last granted requester.
// Latency: o_grant is combinational from i_request and the registered pointer.
// Backpressure: pointer only advances when i_grant_enable is high and a grant is issued.
module rgen_round_robin_arbiter #(
    parameter int REQUESTERS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REQUESTERS-1:0] i_request,
    input  logic                  i_grant_enable,
    output logic [REQUESTERS-1:0] o_grant
);

    localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    // Reset points at the last requester so requester 0 is searched first
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(REQUESTERS - 1);

    logic [PTR_W-1:0] last_q;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_found;

    // First pass looks above the pointer, second pass wraps around to the bottom
    always_comb begin
        o_grant     = '0;
        grant_idx   = last_q;
        grant_found = 1'b0;
        for (int j = 0; j < REQUESTERS; j++) begin
            if (!grant_found && (j > int'(last_q)) && i_request[j]) begin
                o_grant[j]  = 1'b1;
                grant_idx   = PTR_W'(j);
                grant_found = 1'b1;
            end
        end
        for (int j = 0; j < REQUESTERS; j++) begin
            if (!grant_found && (j <= int'(last_q)) && i_request[j]) begin
                o_grant[j]  = 1'b1;
                grant_idx   = PTR_W'(j);
                grant_found = 1'b1;
            end
        end
    end

    // Remember the winner so it gets lowest priority next time
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= PTR_RESET;
        end else if (i_grant_enable && grant_found) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/rgen_register_access_arbiter.sv
// Shares one register bank between HOSTS requesters: grant, strobe decoders, return status/data.
// Latency: strobe one cycle after the request is seen in IDLE, done the cycle after; 3 cycles/access.
// Backpressure: requesters hold i_host_request until their done pulse; losers wait in round-robin order.
module rgen_register_access_arbiter
    import rgen_pkg::*;
#(
    parameter int HOSTS         = 2,
    parameter int REGISTERS     = 4,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [HOSTS-1:0]                i_host_request,
    input  logic [HOSTS-1:0]                i_host_write,
    input  logic [HOSTS*ADDRESS_WIDTH-1:0]  i_host_address,
    input  logic [HOSTS*DATA_WIDTH-1:0]     i_host_write_data,
    output logic [HOSTS-1:0]                o_host_done,
    output logic                            o_host_error,
    output logic [DATA_WIDTH-1:0]           o_host_read_data,
    output logic [ADDRESS_WIDTH-1:0]        o_address,
    output logic                            o_read,
    output logic                            o_write,
    output logic [DATA_WIDTH-1:0]           o_write_data,
    input  logic [REGISTERS-1:0]            i_select,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_read_data
);

    state_t                   state_q;
    logic [HOSTS-1:0]         grant;
    logic [HOSTS-1:0]         grant_q;
    logic                     grant_enable;
    logic                     write_q;
    logic                     grant_write;
    logic [ADDRESS_WIDTH-1:0] grant_address;
    logic [DATA_WIDTH-1:0]    grant_write_data;
    logic                     select_hit;
    logic [DATA_WIDTH-1:0]    mux_data;
    logic                     resp_error;
    logic [DATA_WIDTH-1:0]    resp_data;

    // Grants are only taken while the bank is free
    assign grant_enable = (state_q == ST_IDLE);

    rgen_round_robin_arbiter #(
        .REQUESTERS (HOSTS)
    ) u_arbiter (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_request      (i_host_request),
        .i_grant_enable (grant_enable),
        .o_grant        (grant)
    );

    // Pick the granted host's command fields (grant is one-hot)
    always_comb begin
        grant_write      = 1'b0;
        grant_address    = '0;
        grant_write_data = '0;
        for (int h = 0; h < HOSTS; h++) begin
            if (grant[h]) begin
                grant_write      = i_host_write[h];
                grant_address    = i_host_address[h*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                grant_write_data = i_host_write_data[h*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // OR-mux of every selected slice; only trusted when exactly one select is set
    always_comb begin
        mux_data = '0;
        for (int r = 0; r < REGISTERS; r++) begin
            if (i_select[r]) begin
                mux_data = mux_data | i_read_data[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // No hit or multiple hits are both errors; writes never return data
    assign select_hit = $onehot(i_select);
    assign resp_error = select_hit ? RESP_OK : RESP_ERR;
    assign resp_data  = (select_hit && !write_q) ? mux_data : '0;

    // Access sequencer: latch command in IDLE, strobe in ACCESS, pulse done in RESPOND
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= ST_IDLE;
            grant_q          <= '0;
            write_q          <= 1'b0;
            o_address        <= '0;
            o_write_data     <= '0;
            o_read           <= 1'b0;
            o_write          <= 1'b0;
            o_host_done      <= '0;
            o_host_error     <= 1'b0;
            o_host_read_data <= '0;
        end else begin
            o_read           <= 1'b0;
            o_write          <= 1'b0;
            o_host_done      <= '0;
            o_host_error     <= 1'b0;
            o_host_read_data <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|i_host_request) begin
                        grant_q      <= grant;
                        write_q      <= grant_write;
                        o_address    <= grant_address;
                        o_write_data <= grant_write_data;
                        o_read       <= !grant_write;
                        o_write      <= grant_write;
                        state_q      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    o_host_done      <= grant_q;
                    o_host_error     <= resp_error;
                    o_host_read_data <= resp_data;
                    state_q          <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgen_register_access_arbiter.sv
// Self-checking bench: table vectors, hand-written corner sequences, random traffic vs a transaction model.
// Latency: n/a.
// Backpressure: hosts hold requests until done, then may drop or re-request.
module tb_rgen_register_access_arbiter;

    localparam int HOSTS     = 2;
    localparam int REGISTERS = 4;
    localparam int AW        = 16;
    localparam int DW        = 32;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [HOSTS-1:0]        i_host_request = '0;
    logic [HOSTS-1:0]        i_host_write = '0;
    logic [HOSTS*AW-1:0]     i_host_address = '0;
    logic [HOSTS*DW-1:0]     i_host_write_data = '0;
    logic [HOSTS-1:0]        o_host_done;
    logic                    o_host_error;
    logic [DW-1:0]           o_host_read_data;
    logic [AW-1:0]           o_address;
    logic                    o_read;
    logic                    o_write;
    logic [DW-1:0]           o_write_data;
    logic [REGISTERS-1:0]    i_select = '0;
    logic [REGISTERS*DW-1:0] i_read_data = '0;

    always #5 clk = ~clk;

    rgen_register_access_arbiter #(
        .HOSTS(HOSTS), .REGISTERS(REGISTERS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_host_request(i_host_request), .i_host_write(i_host_write),
        .i_host_address(i_host_address), .i_host_write_data(i_host_write_data),
        .o_host_done(o_host_done), .o_host_error(o_host_error),
        .o_host_read_data(o_host_read_data), .o_address(o_address),
        .o_read(o_read), .o_write(o_write), .o_write_data(o_write_data),
        .i_select(i_select), .i_read_data(i_read_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // The bank is busy for three cycles per access: strobe the cycle after the grant,
    // done the cycle after that, and free again the cycle after done.
    int            cyc, free_at, strobe_at, done_at, last_win, m_win, model_grants;
    bit            found;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_err;
    logic [DW-1:0] m_rdata;
    logic [HOSTS-1:0] exp_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; free_at = 0; strobe_at = -1; done_at = -1; last_win = HOSTS - 1;
        end else begin
            if (cyc == strobe_at) begin
                m_err   = ($countones(i_select) != 1);
                m_rdata = '0;
                if (!m_err && !m_write)
                    for (int r = 0; r < REGISTERS; r++)
                        if (i_select[r]) m_rdata = i_read_data[r*DW +: DW];
            end
            if (cyc >= free_at && i_host_request != '0) begin
                found = 0;
                for (int i = 1; i <= HOSTS; i++)
                    if (!found && i_host_request[(last_win + i) % HOSTS]) begin
                        found = 1;
                        m_win = (last_win + i) % HOSTS;
                    end
                last_win  = m_win;
                m_write   = i_host_write[m_win];
                m_addr    = i_host_address[m_win*AW +: AW];
                m_wdata   = i_host_write_data[m_win*DW +: DW];
                strobe_at = cyc + 1;
                done_at   = cyc + 2;
                free_at   = cyc + 3;
                model_grants++;
            end
            cyc++;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_read", o_read, 0);
            chk("rst_write", o_write, 0);
            chk("rst_done", o_host_done, 0);
            chk("rst_error", o_host_error, 0);
            chk("rst_rdata", o_host_read_data, 0);
            chk("rst_address", o_address, 0);
            chk("rst_wdata", o_write_data, 0);
        end else begin
            exp_done = '0;
            if (cyc == done_at) exp_done[m_win] = 1'b1;
            chk("model_read", o_read, (cyc == strobe_at) && !m_write);
            chk("model_write", o_write, (cyc == strobe_at) && m_write);
            chk("model_done", o_host_done, exp_done);
            if (cyc == strobe_at) begin
                chk("model_address", o_address, m_addr);
                chk("model_wdata", o_write_data, m_wdata);
            end
            if (cyc == done_at) begin
                chk("model_error", o_host_error, m_err);
                chk("model_rdata", o_host_read_data, m_rdata);
            end
        end
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        int                    host;
        logic                  write;
        logic [AW-1:0]         addr;
        logic [DW-1:0]         wdata;
        logic [REGISTERS-1:0]  sel;
        logic                  exp_err;
        logic [DW-1:0]         exp_data;
    } vec_t;

    localparam logic [REGISTERS*DW-1:0] BANK_DATA =
        {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};

    vec_t vecs[8];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_host(input int h, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_host_request[h]           = 1'b1;
        i_host_write[h]             = wr;
        i_host_address[h*AW +: AW]  = a;
        i_host_write_data[h*DW +: DW] = d;
    endtask

    task automatic run_vec(input vec_t v);
        logic [HOSTS-1:0] oh;
        oh = '0;
        oh[v.host] = 1'b1;
        set_host(v.host, v.write, v.addr, v.wdata);
        i_select    = v.sel;
        i_read_data = BANK_DATA;
        tick();
        chk("vec_strobe_read", o_read, !v.write);
        chk("vec_strobe_write", o_write, v.write);
        chk("vec_address", o_address, v.addr);
        tick();
        chk("vec_done", o_host_done, oh);
        chk("vec_error", o_host_error, v.exp_err);
        chk("vec_rdata", o_host_read_data, v.exp_data);
        tick();
        i_host_request[v.host] = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        tick();
        #2 rst_n = 1'b0;
        i_host_request = '0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    int                order[4];
    int                at[4];
    int                n_done;
    int                dut_dones;
    logic [HOSTS-1:0]  done_prev;
    bit                allow;

    initial begin
        vecs[0] = '{0, 1'b0, 16'h0004, 32'h0,        4'b0010, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 16'h0010, 32'hCAFE0001, 4'b0000, 1'b1, 32'h0};
        vecs[2] = '{0, 1'b0, 16'h0008, 32'h0,        4'b0101, 1'b1, 32'h0};
        vecs[3] = '{1, 1'b0, 16'h000C, 32'h0,        4'b1000, 1'b0, 32'h33333333};
        vecs[4] = '{0, 1'b1, 16'h0004, 32'h12345678, 4'b0010, 1'b0, 32'h0};
        vecs[5] = '{1, 1'b0, 16'h0020, 32'h0,        4'b0000, 1'b1, 32'h0};
        vecs[6] = '{0, 1'b1, 16'h0000, 32'h9ABCDEF0, 4'b1111, 1'b1, 32'h0};
        vecs[7] = '{1, 1'b0, 16'h0000, 32'h0,        4'b0001, 1'b0, 32'h11111111};

        // Reset state (also compared every cycle by the checker)
        tick();
        tick();
        chk("reset_done", o_host_done, 0);
        chk("reset_strobe", {o_read, o_write}, 0);
        #2 rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Contention: fresh reset, both hosts request continuously
        do_reset();
        for (int i = 0; i < 4; i++) begin order[i] = -1; at[i] = -1; end
        n_done = 0;
        set_host(0, 1'b0, 16'h0100, 32'h0);
        set_host(1, 1'b0, 16'h0200, 32'h0);
        i_select = 4'b0001;
        for (int k = 1; k <= 20 && n_done < 4; k++) begin
            tick();
            for (int h = 0; h < HOSTS; h++)
                if (o_host_done[h] && n_done < 4) begin
                    order[n_done] = h;
                    at[n_done] = k;
                    n_done++;
                end
        end
        tick();
        i_host_request = '0;
        chk("contention_count", n_done, 4);
        for (int i = 0; i < 4; i++) begin
            chk("contention_order", order[i], i % 2);
            chk("contention_cycle", at[i], 2 + 3 * i);
        end
        tick();

        // Back-to-back: host0 re-requests in the IDLE cycle after done with a new address
        set_host(0, 1'b0, 16'h0004, 32'h0);
        i_select = 4'b0010;
        tick();
        chk("b2b_first_strobe", o_read, 1);
        chk("b2b_first_addr", o_address, 16'h0004);
        tick();
        chk("b2b_first_done", o_host_done, 2'b01);
        tick();
        i_host_address[0 +: AW] = 16'h0008;
        chk("b2b_idle_gap", o_read, 0);
        tick();
        chk("b2b_second_strobe", o_read, 1);
        chk("b2b_second_addr", o_address, 16'h0008);
        tick();
        chk("b2b_second_done", o_host_done, 2'b01);
        tick();
        i_host_request = '0;
        tick();

        // Reset mid-access: pointer currently favours host1; reset must restore host0 priority
        set_host(0, 1'b0, 16'h0030, 32'h0);
        i_select = 4'b0001;
        tick();
        chk("abort_strobe_before", o_read, 1);
        #2 rst_n = 1'b0;
        set_host(1, 1'b0, 16'h0040, 32'h0);
        #1;
        chk("abort_read_cleared", o_read, 0);
        chk("abort_addr_cleared", o_address, 0);
        tick();
        chk("abort_no_done", o_host_done, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("abort_regrant_addr", o_address, 16'h0030);
        tick();
        chk("abort_host0_done", o_host_done, 2'b01);
        tick();
        i_host_request[0] = 1'b0;
        tick();
        chk("abort_host1_addr", o_address, 16'h0040);
        tick();
        chk("abort_host1_done", o_host_done, 2'b10);
        tick();
        i_host_request = '0;
        tick();

        // Random traffic: model checks every cycle; then drain and compare transaction counts
        model_grants = 0;
        dut_dones = 0;
        done_prev = '0;
        for (int c = 0; c < 1530; c++) begin
            allow = (c < 1500);
            for (int h = 0; h < HOSTS; h++) begin
                if (i_host_request[h]) begin
                    if (done_prev[h]) begin
                        if (allow && $urandom_range(0, 1) == 1)
                            set_host(h, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
                        else
                            i_host_request[h] = 1'b0;
                    end else if ($urandom_range(0, 7) == 0) begin
                        i_host_address[h*AW +: AW]    = AW'($urandom);
                        i_host_write_data[h*DW +: DW] = $urandom;
                    end
                end else if (allow && $urandom_range(0, 2) == 0) begin
                    set_host(h, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
                end
                done_prev[h] = o_host_done[h];
            end
            if (o_host_done != '0) dut_dones++;
            case ($urandom_range(0, 3))
                0:       i_select = '0;
                3:       i_select = REGISTERS'($urandom);
                default: i_select = REGISTERS'(1 << $urandom_range(0, REGISTERS - 1));
            endcase
            for (int r = 0; r < REGISTERS; r++) i_read_data[r*DW +: DW] = $urandom;
            tick();
        end
        chk("random_txn_count", dut_dones, model_grants);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
